// File: rtl/stopwatch_counter_chain.sv
// stopwatch_counter_chain
// Cascaded up/down mod-N digit chain with a run/stop/done state machine,
// preset load with per-digit clamping, overflow pulse and terminal-count
// detection. Optional lap capture register is built only when the macro
// STOPWATCH_LAP_EN is defined; otherwise o_lap_val is tied to zero.
// i_reset is asynchronous and active-low.
module stopwatch_counter_chain #(
   parameter int                    DIGITS = 4,
   parameter logic [4*DIGITS-1:0]   MODS   = 16'h6A6A
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_tick,
   input  logic                  i_start,
   input  logic                  i_ups,
   input  logic                  i_load,
   input  logic [4*DIGITS-1:0]   i_load_val,
   input  logic                  i_lap,
   output logic [4*DIGITS-1:0]   o_count,
   output logic [4*DIGITS-1:0]   o_lap_val,
   output logic                  o_running,
   output logic                  o_done,
   output logic                  o_wrap
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t         r_state, w_state_next;
   logic [W-1:0]   r_count, w_count_next;
   logic           r_running, r_done, r_wrap;
   logic           w_wrap_next;

   // Carry/borrow ripple: w_carry[i] means every digit below i is at its
   // maximum, w_borrow[i] means every digit below i is zero.
   logic [DIGITS:0] w_carry;
   logic [DIGITS:0] w_borrow;
   logic [W-1:0]    w_inc;
   logic [W-1:0]    w_dec;
   logic [W-1:0]    w_clamp;

   assign w_carry[0]  = 1'b1;
   assign w_borrow[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         localparam logic [3:0] MOD = MODS[4*gi +: 4];
         localparam logic [3:0] TOP = MOD - 4'd1;

         if (MOD < 4'd2) begin : g_bad_mod
            $error("stopwatch_counter_chain: digit modulus must be 2..15");
         end

         logic [3:0] w_digit;
         logic [3:0] w_lv;
         assign w_digit = r_count[4*gi +: 4];
         assign w_lv    = i_load_val[4*gi +: 4];

         assign w_carry[gi+1]  = w_carry[gi]  & (w_digit == TOP);
         assign w_borrow[gi+1] = w_borrow[gi] & (w_digit == 4'd0);

         assign w_inc[4*gi +: 4] = !w_carry[gi]  ? w_digit :
                                   (w_digit == TOP)  ? 4'd0 : w_digit + 4'd1;
         assign w_dec[4*gi +: 4] = !w_borrow[gi] ? w_digit :
                                   (w_digit == 4'd0) ? TOP  : w_digit - 4'd1;

         // Out-of-range preset nibbles saturate to the digit's maximum.
         assign w_clamp[4*gi +: 4] = (w_lv >= MOD) ? TOP : w_lv;
      end
   endgenerate

   logic w_count_zero;
   logic w_count_max;
   assign w_count_zero = w_borrow[DIGITS];
   assign w_count_max  = w_carry[DIGITS];

   // Next-state, next-count and overflow pulse; load has top priority.
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_wrap_next  = 1'b0;
      if (i_load) begin
         w_state_next = ST_IDLE;
         w_count_next = w_clamp;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  w_state_next = (!i_ups && w_count_zero) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (!i_start) begin
                  w_state_next = ST_IDLE;
               end else if (i_tick) begin
                  if (i_ups) begin
                     w_count_next = w_inc;
                     w_wrap_next  = w_count_max;
                  end else if (!w_count_zero) begin
                     w_count_next = w_dec;
                     if (w_dec == '0) begin
                        w_state_next = ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (!i_start) begin
                  w_state_next = ST_IDLE;
               end
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   // State, count and flag registers; flags are decoded from the next state
   // so they line up with the state they describe.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_wrap    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_count   <= w_count_next;
         r_running <= (w_state_next == ST_RUN);
         r_done    <= (w_state_next == ST_DONE);
         r_wrap    <= w_wrap_next;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic [W-1:0] r_lap;

   // Lap captures the pre-update count on any strobe, in any state.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_lap <= '0;
      end else if (i_lap) begin
         r_lap <= r_count;
      end
   end

   assign o_lap_val = r_lap;
`else
   logic w_unused_lap;
   assign w_unused_lap = i_lap;
   assign o_lap_val    = '0;
`endif

   assign o_count   = r_count;
   assign o_running = r_running;
   assign o_done    = r_done;
   assign o_wrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_counter_chain.sv
// Testbench for stopwatch_counter_chain: the stimulus process drives inputs
// on the falling edge and pushes the reference model's expected outputs into
// a queue; a monitor pops and compares one entry after every rising edge.
// The reference model treats the count as a single mixed-radix integer.
module tb_stopwatch_counter_chain;

   localparam int            DIGITS = 4;
   localparam logic [15:0]   MODS   = 16'h6A6A;
   localparam int            W      = 4 * DIGITS;
   localparam int            M_IDLE = 0;
   localparam int            M_RUN  = 1;
   localparam int            M_DONE = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           tick = 1'b0, start = 1'b0, ups = 1'b1, load = 1'b0, lap = 1'b0;
   logic [W-1:0]   load_val = '0;
   logic [W-1:0]   count, lap_val;
   logic           running, done, wrap;

   stopwatch_counter_chain #(.DIGITS(DIGITS), .MODS(MODS)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_tick     (tick),
      .i_start    (start),
      .i_ups      (ups),
      .i_load     (load),
      .i_load_val (load_val),
      .i_lap      (lap),
      .o_count    (count),
      .o_lap_val  (lap_val),
      .o_running  (running),
      .o_done     (done),
      .o_wrap     (wrap)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] c;
      logic [W-1:0] l;
      logic         r;
      logic         d;
      logic         w;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state
   int           m_state = M_IDLE;
   logic [W-1:0] m_count = '0;
   logic [W-1:0] m_lap   = '0;
   logic         m_wrap  = 1'b0;

   function automatic int modof(int i);
      logic [15:0] m;
      m = MODS;
      return int'(m[4*i +: 4]);
   endfunction

   function automatic int total_states();
      int p = 1;
      for (int i = 0; i < DIGITS; i++) p *= modof(i);
      return p;
   endfunction

   function automatic int to_val(logic [W-1:0] c);
      int v = 0;
      int wgt = 1;
      for (int i = 0; i < DIGITS; i++) begin
         v += int'(c[4*i +: 4]) * wgt;
         wgt *= modof(i);
      end
      return v;
   endfunction

   function automatic logic [W-1:0] from_val(int v);
      logic [W-1:0] c = '0;
      int x = v;
      for (int i = 0; i < DIGITS; i++) begin
         c[4*i +: 4] = 4'(x % modof(i));
         x = x / modof(i);
      end
      return c;
   endfunction

   function automatic exp_t snapshot();
      exp_t e;
      e.c = m_count;
      e.l = m_lap;
      e.r = (m_state == M_RUN);
      e.d = (m_state == M_DONE);
      e.w = m_wrap;
      return e;
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_count = '0;
      m_lap   = '0;
      m_wrap  = 1'b0;
   endtask

   task automatic model_step();
      int v;
      logic [W-1:0] prev;
      prev   = m_count;
      m_wrap = 1'b0;
`ifdef STOPWATCH_LAP_EN
      if (lap) m_lap = prev;
`endif
      if (load) begin
         for (int i = 0; i < DIGITS; i++) begin
            int n;
            n = int'(load_val[4*i +: 4]);
            m_count[4*i +: 4] = 4'((n >= modof(i)) ? modof(i) - 1 : n);
         end
         m_state = M_IDLE;
      end else begin
         v = to_val(prev);
         case (m_state)
            M_IDLE: if (start) m_state = (!ups && v == 0) ? M_DONE : M_RUN;
            M_RUN: begin
               if (!start) m_state = M_IDLE;
               else if (tick) begin
                  if (ups) begin
                     if (v == total_states() - 1) begin
                        v = 0;
                        m_wrap = 1'b1;
                     end else v = v + 1;
                  end else if (v > 0) begin
                     v = v - 1;
                     if (v == 0) m_state = M_DONE;
                  end
                  m_count = from_val(v);
               end
            end
            default: if (!start) m_state = M_IDLE;
         endcase
      end
   endtask

   // One clock of stimulus: drive on the falling edge, predict, enqueue.
   task automatic cycle(input logic t, input logic s, input logic u,
                        input logic ld, input logic [W-1:0] lv, input logic lp);
      @(negedge clk);
      reset = 1'b1;
      tick = t; start = s; ups = u; load = ld; load_val = lv; lap = lp;
      model_step();
      q.push_back(snapshot());
   endtask

   task automatic check1(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Assert reset between edges and confirm outputs clear before any edge.
   task automatic async_reset();
      @(negedge clk);
      tick = 1'b0; start = 1'b1; load = 1'b0; lap = 1'b0;
      #2 reset = 1'b0;
      #1;
      check1("async_count",   count,            '0);
      check1("async_lap",     lap_val,          '0);
      check1("async_flags",   {running, done, wrap}, '0);
      $display("async reset: count=%h lap=%h run=%b done=%b wrap=%b",
               count, lap_val, running, done, wrap);
      model_reset();
      q.push_back(snapshot());
   endtask

   // Monitor: one comparison set per rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            cyc++;
            check1("count",   count,   e.c);
            check1("lap_val", lap_val, e.l);
            check1("running", W'(running), W'(e.r));
            check1("done",    W'(done),    W'(e.d));
            check1("wrap",    W'(wrap),    W'(e.w));
            $display("cyc %0d count=%h lap=%h run=%b done=%b wrap=%b",
                     cyc, count, lap_val, running, done, wrap);
         end
      end
   end

   initial begin
      logic r_ups;
      int   wait_cnt;
      model_reset();
      repeat (2) @(negedge clk);

      // Up count 600 ticks from zero
      cycle(0, 0, 1, 1, 16'h0000, 0);
      cycle(0, 1, 1, 0, 16'h0000, 0);
      for (int i = 0; i < 600; i++) cycle(1, 1, 1, 0, 16'h0000, 0);

      // Overflow
      cycle(0, 0, 1, 1, 16'h5959, 0);
      cycle(0, 1, 1, 0, 16'h0000, 0);
      cycle(1, 1, 1, 0, 16'h0000, 0);
      repeat (3) cycle(0, 1, 1, 0, 16'h0000, 0);

      // Countdown to terminal, extra ticks, stop
      cycle(0, 0, 0, 1, 16'h0010, 0);
      cycle(0, 1, 0, 0, 16'h0000, 0);
      for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 16'h0000, 0);
      for (int i = 0; i < 5; i++)  cycle(1, 1, 0, 0, 16'h0000, 0);
      cycle(0, 0, 0, 0, 16'h0000, 0);
      cycle(0, 1, 0, 0, 16'h0000, 0);
      cycle(0, 0, 0, 0, 16'h0000, 0);

      // Clamp, then load coincident with a tick
      cycle(0, 0, 1, 1, 16'hFFFF, 0);
      cycle(0, 0, 1, 1, 16'h0005, 0);
      cycle(0, 1, 1, 0, 16'h0000, 0);
      cycle(1, 1, 1, 1, 16'h0234, 0);
      cycle(0, 1, 1, 0, 16'h0000, 0);

      // Async reset while running at 0123
      cycle(0, 0, 1, 1, 16'h0123, 1);
      cycle(0, 1, 1, 0, 16'h0000, 0);
      cycle(0, 1, 1, 0, 16'h0000, 1);
      async_reset();
      repeat (3) cycle(1, 0, 1, 0, 16'h0000, 0);
      cycle(0, 1, 1, 0, 16'h0000, 0);

      // Lap coincident with a tick at 0009
      cycle(0, 0, 1, 1, 16'h0009, 0);
      cycle(0, 1, 1, 0, 16'h0000, 0);
      cycle(1, 1, 1, 0, 16'h0000, 1);
      cycle(0, 1, 1, 0, 16'h0000, 0);

      // Randomised traffic
      r_ups = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         logic [W-1:0] lv;
         if ($urandom_range(0, 63) == 0) r_ups = ~r_ups;
         lv = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
         cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) != 0), r_ups,
               ($urandom_range(0, 39) == 0), lv, ($urandom_range(0, 7) == 0));
      end

      // Drain with a bounded wait
      wait_cnt = 0;
      while (q.size() > 0 && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
